// File: rtl/uart_pkg.sv
// Shared UART definitions: the receive/transmit state encoding and the
// parameter limits that both directions accept.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int MIN_DATA_BITS  = 5;
  localparam int MAX_DATA_BITS  = 9;
  localparam int MIN_OVERSAMPLE = 8;
  localparam int MAX_OVERSAMPLE = 32;

endpackage

// File: rtl/uart_rx_param_if.sv
// Word-level port between the UART receiver and its consumer.
//
// Handshake: rdy rises when a word is committed and stays high until the
// consumer pulses rdy_clr for one cycle; rdy then falls on the next edge.
// data and the status flags belong to the presented word and hold until the
// next commit. A commit while rdy is still high (and no rdy_clr that cycle)
// overwrites the word and sets overrun; a commit coinciding with rdy_clr
// simply presents the new word.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 rdy_clr;
  logic                 rdy;
  logic [DATA_BITS-1:0] data;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    input  rdy_clr,
    output rdy, data, frame_err, parity_err, overrun
  );

  modport slave (
    output rdy_clr,
    input  rdy, data, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input. Both stages
// reset to 1 so a line held in reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // shift the raw input through two stages
  always_comb begin
    sync_d = {sync_q[0], d};
  end

  // synchronizer register, reset to the idle level
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[1];
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver. Oversamples rx on clken, recovers LSB-first
// frames and presents each word through uart_rx_param_if.
// Optional feature: define UART_RX_PARITY_EN to compile in the parity bit
// and a live parity_err; without it parity_err is tied 0.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              clken,
  input  logic              rx,
  uart_rx_param_if.master   bus,
  output uart_state_e       state_dbg
);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);

  // Reject parameter sets outside the supported range at elaboration.
  if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS ||
      OVERSAMPLE < MIN_OVERSAMPLE || OVERSAMPLE > MAX_OVERSAMPLE ||
      (OVERSAMPLE & (OVERSAMPLE - 1)) != 0 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_param: unsupported parameter set");
  end

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk_50m),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 fe_pend_q, fe_pend_d;
  logic                 commit;
  logic                 rdy_q, rdy_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                 pe_pend_q, pe_pend_d;
  logic                 parity_err_q, parity_err_d;
`endif

  // frame FSM: advances only on clken, samples at bit centres
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    fe_pend_d  = fe_pend_q;
    commit     = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_pend_d  = pe_pend_q;
`endif
    if (clken) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            cnt_d   = '0;
            state_d = START;
          end
        end
        START: begin
          if (cnt_q == HALF_CNT) begin
            cnt_d = '0;
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d    = DATA;
              bit_cnt_d  = '0;
              stop_cnt_d = 1'b0;
              fe_pend_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
              pe_pend_d  = 1'b0;
`endif
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_CNT) begin
            cnt_d     = '0;
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == FULL_CNT) begin
            cnt_d     = '0;
            pe_pend_d = ((^shift_q) ^ rx_s) != 1'(PARITY_ODD);
            state_d   = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt_q == FULL_CNT) begin
            cnt_d = '0;
            if (!rx_s) fe_pend_d = 1'b1;
            if (stop_cnt_q == LAST_STOP) begin
              // committing at the stop centre lets the next start edge be
              // seen from mid-stop-bit onward
              commit  = 1'b1;
              state_d = IDLE;
            end else begin
              stop_cnt_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // word presentation: commit wins over rdy_clr, overrun on unread overwrite
  always_comb begin
    rdy_d       = rdy_q;
    data_d      = data_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (commit) begin
      rdy_d       = 1'b1;
      data_d      = shift_q;
      frame_err_d = fe_pend_d;
`ifdef UART_RX_PARITY_EN
      parity_err_d = pe_pend_q;
`endif
      if (rdy_q && !bus.rdy_clr) overrun_d = 1'b1;
    end else if (bus.rdy_clr) begin
      rdy_d     = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // state and output registers; reset aborts any frame in progress
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      shift_q     <= '0;
      fe_pend_q   <= 1'b0;
      rdy_q       <= 1'b0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_pend_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      shift_q     <= shift_d;
      fe_pend_q   <= fe_pend_d;
      rdy_q       <= rdy_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      pe_pend_q    <= pe_pend_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.rdy       = rdy_q;
  assign bus.data      = data_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif
  assign state_dbg = state_q;
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for the FPGA transceiver datapath. Oversamples an asynchronous serial line on a clock-enable tick, recovers LSB-first frames with configurable data width, optional parity and one or two stop bits, and presents each word with a ready/clear handshake plus framing, parity and overrun status. Sits between the pad-side `rx` line and the word-level consumer, alongside the baud-tick generator that drives `clken`.

## Interface
- `DATA_BITS`, 8, data bits per frame (5–9)
- `OVERSAMPLE`, 16, `clken` ticks per bit; power of two, 8–32
- `STOP_BITS`, 1, stop bits checked (1 or 2)
- `PARITY_ODD`, 0, 1 = odd parity, 0 = even; only used when parity is compiled in
- `clk_50m`  in  1  system clock
- `rst_n`  in  1  reset; synchronous, active-low
- `clken`  in  1  oversample tick, one `clk_50m` cycle wide, `OVERSAMPLE`×baud
- `rx`  in  1  asynchronous serial input; idle high
- `rdy_clr`  in  1  consumer acknowledge, one-cycle pulse
- `rdy`  out  1  word available
- `data`  out  DATA_BITS  received word, LSB = first bit on the line
- `frame_err`  out  1  a stop bit of the presented word sampled low
- `parity_err`  out  1  parity mismatch on the presented word
- `overrun`  out  1  a word was overwritten before `rdy_clr`

## Operation
- `rx` passes through a 2-flop synchronizer clocked every cycle, independent of `clken`. Both flops reset to 1.
- State and sample counter advance only on `clken`. `rdy_clr` and reset act on any cycle.
- States:
  - IDLE: on a low synchronized sample, clear the counter and go to START.
  - START: at count `OVERSAMPLE/2-1`, a high sample is a false start and returns to IDLE. A low sample clears the counter and goes to DATA.
  - DATA: sample at count `OVERSAMPLE-1` (bit centre), shift into the MSB of the shift register and clear the counter. After `DATA_BITS` samples, go to PARITY if compiled in, otherwise STOP.
  - PARITY: sample once at bit centre. Error if the XOR of the data bits and the parity bit is not equal to `PARITY_ODD`.
  - STOP: sample `STOP_BITS` centres. Any low sample sets the pending frame error. After the last centre, commit and go to IDLE, so a start edge is detectable from mid-stop-bit onward.
- Commit writes `data`, `frame_err`, `parity_err` and sets `rdy`=1.
  - Commit while `rdy`=1 and no `rdy_clr` in the same cycle: `overrun`←1 and data is overwritten.
  - Commit in the same cycle as `rdy_clr`: the new word wins. `rdy` stays 1 and `overrun` is unchanged.
- `rdy_clr` with no commit: `rdy`←0 and `overrun`←0. `data` and error flags hold.
- Counter width is $clog2(OVERSAMPLE) and wraps only through explicit clears.

## Timing
- Reset values: `rdy`, `data`, `frame_err`, `parity_err`, `overrun` = 0. State = IDLE, counter = 0, synchronizer = 1.
- `rst_n` low in any state, including mid-frame, aborts the frame on the next edge. No partial word is committed.
- `rx` to synchronized sample: 2 `clk_50m` cycles.
- `rdy` rises 1 cycle after the `clken` cycle that samples the last stop-bit centre. `data` is valid in the same cycle.
- `rdy` falls 1 cycle after `rdy_clr`.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists and the frame is start + `DATA_BITS` + parity + `STOP_BITS` long. `parity_err` is live.
- `UART_RX_PARITY_EN` undefined: the PARITY state and its logic are absent. `parity_err` is tied 0 and `PARITY_ODD` is ignored.

## Structure
- Package `uart_pkg` holds the state enum (IDLE, START, DATA, PARITY, STOP) and bit-width limit constants. These are shared with the transmitter.
- Sub-module `uart_rx_sync` holds the 2-flop synchronizer with reset-to-1. It is reusable by other async inputs.

## Test plan
- 8N1, `OVERSAMPLE`=16, byte 0xA5 at nominal baud -> `data`=0xA5, all flags 0, `rdy` high 1 cycle after the stop-centre tick.
- `rx` low for 4 ticks, then high -> false start: no `rdy`, FSM back in IDLE, next valid frame 0x3C received correctly.
- Frame 0x55 with stop bit driven low -> `rdy`=1, `data`=0x55, `frame_err`=1.
- Frames 0x11 then 0x22 with no `rdy_clr` -> `data`=0x22, `overrun`=1. A `rdy_clr` pulse then gives `rdy`=0 and `overrun`=0 next cycle. A `rdy_clr` coinciding with a commit keeps `rdy`=1 and `overrun`=0.
- `UART_RX_PARITY_EN` with `PARITY_ODD`=0, `DATA_BITS`=7, word 0x41 with parity bit 1 -> `parity_err`=1. Correct parity bit 0 -> `parity_err`=0.
- `rst_n` low for one cycle mid-DATA of 0xF0 -> all outputs 0 next cycle. The following frame 0x0F gives `data`=0x0F with no error flags.
